// File: rtl/clk_period_monitor.sv
// Single-shot high/low/period measurement of an asynchronous test clock, in clk cycles.
// Define CLKMON_CHECK_EN to build the tolerance checker that drives err_o.
module clk_period_monitor #(
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mon_clk_i,
  input  logic             start_i,
  input  logic [CNT_W-1:0] exp_high_i,
  input  logic [CNT_W-1:0] exp_low_i,
  input  logic [CNT_W-1:0] tol_i,
  output logic             busy_o,
  output logic             valid_o,
  output logic [CNT_W-1:0] high_cnt_o,
  output logic [CNT_W-1:0] low_cnt_o,
  output logic [CNT_W:0]   period_cnt_o,
  output logic             timeout_o,
  output logic             err_o
);

  typedef enum logic [1:0] {IDLE, ARM, HIGH, LOW} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t                 state, state_nx;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s, s_d, rise, fall;
  logic [CNT_W-1:0]       cnt, cnt_nx;
  logic [CNT_W-1:0]       hi_meas, hi_meas_nx;
  logic                   done_valid, done_to;

  assign s    = sync_q[SYNC_STAGES-1];
  assign rise = s & ~s_d;
  assign fall = ~s & s_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      s_d    <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], mon_clk_i};
      s_d    <= s;
    end
  end

  // A qualifying edge is checked before saturation so the edge wins a tie.
  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    hi_meas_nx = hi_meas;
    done_valid = 1'b0;
    done_to    = 1'b0;
    case (state)
      IDLE: begin
        if (start_i) begin
          state_nx = ARM;
          cnt_nx   = CNT_ONE;
        end
      end
      ARM: begin
        if (rise) begin
          state_nx = HIGH;
          cnt_nx   = CNT_ONE;
        end else if (cnt == CNT_MAX) begin
          state_nx = IDLE;
          cnt_nx   = '0;
          done_to  = 1'b1;
        end else begin
          cnt_nx = cnt + CNT_ONE;
        end
      end
      HIGH: begin
        if (fall) begin
          state_nx   = LOW;
          hi_meas_nx = cnt;
          cnt_nx     = CNT_ONE;
        end else if (cnt == CNT_MAX) begin
          state_nx = IDLE;
          cnt_nx   = '0;
          done_to  = 1'b1;
        end else begin
          cnt_nx = cnt + CNT_ONE;
        end
      end
      LOW: begin
        if (rise) begin
          state_nx   = IDLE;
          done_valid = 1'b1;
        end else if (cnt == CNT_MAX) begin
          state_nx = IDLE;
          cnt_nx   = '0;
          done_to  = 1'b1;
        end else begin
          cnt_nx = cnt + CNT_ONE;
        end
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

  // High count is held privately so a timeout in LOW leaves published results intact.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      hi_meas      <= '0;
      busy_o       <= 1'b0;
      valid_o      <= 1'b0;
      timeout_o    <= 1'b0;
      high_cnt_o   <= '0;
      low_cnt_o    <= '0;
      period_cnt_o <= '0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      hi_meas   <= hi_meas_nx;
      busy_o    <= (state_nx != IDLE);
      valid_o   <= done_valid;
      timeout_o <= done_to;
      if (done_valid) begin
        high_cnt_o   <= hi_meas;
        low_cnt_o    <= cnt;
        period_cnt_o <= {1'b0, hi_meas} + {1'b0, cnt};
      end
    end
  end

`ifdef CLKMON_CHECK_EN
  logic [CNT_W-1:0] diff_hi, diff_lo;
  logic             err_q;

  assign diff_hi = (hi_meas >= exp_high_i) ? hi_meas - exp_high_i : exp_high_i - hi_meas;
  assign diff_lo = (cnt >= exp_low_i) ? cnt - exp_low_i : exp_low_i - cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          err_q <= 1'b0;
    else if (done_valid) err_q <= (diff_hi > tol_i) || (diff_lo > tol_i);
  end

  assign err_o = err_q;
`else
  logic unused_check_ins;
  assign unused_check_ins = ^{exp_high_i, exp_low_i, tol_i};
  assign err_o = 1'b0;
`endif

endmodule
